reg_write_arbiter: RTL and testbench

Shared-register write arbiter: grants N requesters exclusive, one-at-a-time write access to a single WIDTH-bit bank of D flip-flops (q/qbar pair). It sequences every write through a three-state FSM, selects winners round-robin, and acknowledges each committed write. It sits between the register-bank users and the flip-flop bank, and it owns the bank's q/qbar outputs.

---
 rtl/reg_write_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_reg_write_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Purpose  : Grants N_REQ requesters one-at-a-time write access to a shared
//            WIDTH-bit register (q/qbar). Every write is sequenced through
//            IDLE -> GRANT -> COMMIT. Winners are picked round-robin, and each
//            committed write gets a one-cycle ack pulse.
// Ports    : clk      - rising-edge clock
//            rst      - asynchronous active-high reset
//            req      - per-requester level write request (held until ack)
//            wr_data  - per-requester write data, requester i at [i*WIDTH +: WIDTH]
//            grant    - one-hot current owner
//            ack      - one-hot, one-cycle commit acknowledge
//            q / qbar - shared register value and its complement
//            busy     - high whenever the FSM is not idle
// Config   : REG_ARB_FIXED_PRIO_EN - when defined, lowest index always wins
//            and the round-robin pointer is removed.
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wr_data,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       qbar,
  output logic                   busy
);

  localparam int                 c_idx_w    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [c_idx_w:0]   c_n_req    = (c_idx_w + 1)'(N_REQ);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_idx_w-1:0] r_owner;
  logic [N_REQ-1:0]   r_grant;
  logic [N_REQ-1:0]   r_ack;
  logic [WIDTH-1:0]   r_q;

  logic [c_idx_w-1:0] w_scan_start;  // first index scanned when arbitrating from IDLE
  logic [c_idx_w-1:0] w_next_start;  // first index scanned when re-arbitrating in COMMIT
  logic [N_REQ-1:0]   w_owner_oh;
  logic [N_REQ-1:0]   w_masked_req;
  logic [WIDTH-1:0]   w_owner_data;
  logic               w_idle_found;
  logic               w_next_found;
  logic [c_idx_w-1:0] w_idle_win;
  logic [c_idx_w-1:0] w_next_win;
  logic [N_REQ-1:0]   w_idle_oh;
  logic [N_REQ-1:0]   w_next_oh;

`ifdef REG_ARB_FIXED_PRIO_EN
  assign w_scan_start = '0;
  assign w_next_start = '0;
`else
  logic [c_idx_w-1:0] r_prio_ptr;

  assign w_scan_start = r_prio_ptr;
  // The pointer moves to the slot after the owner, so the re-arbitration in
  // COMMIT scans from where the pointer will land on this edge.
  assign w_next_start = (r_owner == c_last_idx) ? '0 : r_owner + 1'b1;
`endif

  // Owner decode and data select.
  always_comb begin
    w_owner_oh   = '0;
    w_owner_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_owner == c_idx_w'(i)) begin
        w_owner_oh[i] = 1'b1;
        w_owner_data  = wr_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // The owner is excluded from re-arbitration so a requester still holding
  // req on the ack edge cannot win twice in a row.
  assign w_masked_req = req & ~w_owner_oh;

  // Wrapping priority scan starting at a given index.
  always_comb begin
    logic [c_idx_w:0] idx_a;
    logic [c_idx_w:0] idx_b;
    w_idle_found = 1'b0;
    w_idle_win   = '0;
    w_next_found = 1'b0;
    w_next_win   = '0;
    w_idle_oh    = '0;
    w_next_oh    = '0;
    idx_a        = '0;
    idx_b        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_a = {1'b0, w_scan_start} + (c_idx_w + 1)'(i);
      if (idx_a >= c_n_req) idx_a = idx_a - c_n_req;
      if (!w_idle_found && req[idx_a[c_idx_w-1:0]]) begin
        w_idle_found = 1'b1;
        w_idle_win   = idx_a[c_idx_w-1:0];
      end
      idx_b = {1'b0, w_next_start} + (c_idx_w + 1)'(i);
      if (idx_b >= c_n_req) idx_b = idx_b - c_n_req;
      if (!w_next_found && w_masked_req[idx_b[c_idx_w-1:0]]) begin
        w_next_found = 1'b1;
        w_next_win   = idx_b[c_idx_w-1:0];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      w_idle_oh[i] = w_idle_found && (w_idle_win == c_idx_w'(i));
      w_next_oh[i] = w_next_found && (w_next_win == c_idx_w'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_grant    <= '0;
      r_ack      <= '0;
      r_q        <= '0;
`ifndef REG_ARB_FIXED_PRIO_EN
      r_prio_ptr <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack <= '0;
          if (w_idle_found) begin
            r_owner <= w_idle_win;
            r_grant <= w_idle_oh;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (|(req & w_owner_oh)) begin
            r_q     <= w_owner_data;
            r_ack   <= w_owner_oh;
            r_state <= S_COMMIT;
          end else begin
            // Owner withdrew: abort without touching q or the pointer.
            r_grant <= '0;
            r_state <= S_IDLE;
          end
        end
        S_COMMIT: begin
          r_ack <= '0;
`ifndef REG_ARB_FIXED_PRIO_EN
          r_prio_ptr <= w_next_start;
`endif
          if (w_next_found) begin
            r_owner <= w_next_win;
            r_grant <= w_next_oh;
            r_state <= S_GRANT;
          end else begin
            r_grant <= '0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_grant <= '0;
          r_ack   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign ack   = r_ack;
  assign q     = r_q;
  assign qbar  = ~r_q;
  assign busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_arbiter
// Purpose  : Self-checking bench for reg_write_arbiter. Stimulus issues batches
//            of simultaneous requests; a transaction-level model predicts the
//            service order, data and ack cycle of each write and queues them.
//            An independent monitor pops the queue on every ack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wr_data;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic [W-1:0]   qbar;
  logic           busy;

  reg_write_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wr_data (wr_data),
    .grant   (grant),
    .ack     (ack),
    .q       (q),
    .qbar    (qbar),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ptr   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    oh = N'(1) << i;
  endfunction

  // First pending requester scanning upward from start, wrapping.
  function automatic int pick(input logic [N-1:0] pending, input int start);
    for (int i = 0; i < N; i++) begin
      if (pending[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  function automatic int model_start();
`ifdef REG_ARB_FIXED_PRIO_EN
    return 0;
`else
    return ptr;
`endif
  endfunction

  // Monitor: compare every ack against the scoreboard; q must hold the last
  // committed value at all other times.
  initial begin
    exp_t         e;
    logic [W-1:0] model_q;
    logic [W-1:0] model_qbar;
    model_q = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_q = '0;
        exp_q.delete();
      end else begin
        if (ack != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ack", 32'(ack), 32'(0));
          end else begin
            e = exp_q.pop_front();
            check("ack_owner", 32'(ack), 32'(oh(e.idx)));
            check("grant_at_ack", 32'(grant), 32'(oh(e.idx)));
            check("ack_q_data", 32'(q), 32'(e.data));
            check("ack_cycle", cyc, e.cyc);
            model_q = e.data;
          end
        end
        model_qbar = ~model_q;
        check("q_value", 32'(q), 32'(model_q));
        check("qbar_value", 32'(qbar), 32'(model_qbar));
      end
    end
  end

  // Called just after a negedge with the DUT idle.
  task automatic run_batch(input logic [N-1:0] mask, input bit force_en, input logic [W-1:0] fdata);
    logic [N-1:0] pend;
    exp_t         e;
    int           start_cyc;
    int           k;
    int           w;
    bit           timed_out;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) wr_data[i*W +: W] = force_en ? fdata : W'($urandom);
    end
    start_cyc = cyc;
    pend = mask;
    k = 0;
    while (pend != '0) begin
      w = pick(pend, model_start());
      e.idx  = w;
      e.data = wr_data[w*W +: W];
      e.cyc  = start_cyc + 2 + 2 * k;
      exp_q.push_back(e);
      pend[w] = 1'b0;
      ptr = (w + 1) % N;
      k++;
    end
    req = req | mask;
    timed_out = 1'b1;
    for (int t = 0; t < 4 * N + 8; t++) begin
      @(negedge clk);
      req = req & ~ack;
      if (req == '0) begin
        timed_out = 1'b0;
        break;
      end
    end
    if (timed_out) begin
      n_cmp++;
      n_bad++;
      $display("FAIL batch_timeout: req still 0x%0h, want 0x0 (cycle %0d)", req, cyc);
      req = '0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      ptr = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_abort(input int j);
    wr_data[j*W +: W] = W'($urandom);
    req[j] = 1'b1;
    @(negedge clk);
    check("abort_grant", 32'(grant), 32'(oh(j)));
    check("abort_busy", 32'(busy), 32'(1));
    req[j] = 1'b0;
    @(negedge clk);
    check("abort_grant_drop", 32'(grant), 32'(0));
    check("abort_busy_drop", 32'(busy), 32'(0));
    @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    wr_data = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_q", 32'(q), 32'(0));
    check("reset_qbar", 32'(qbar), 32'(8'hFF));
    check("reset_grant", 32'(grant), 32'(0));
    check("reset_ack", 32'(ack), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    run_batch(4'b1111, 1'b0, '0);    // contention from pointer 0
    run_batch(4'b0100, 1'b1, 8'hA5); // single write, pointer lands on 3
    run_batch(4'b1001, 1'b0, '0);    // wrap: 3 then 0

    // Reset while requester 1 holds the grant.
    wr_data[1*W +: W] = 8'h3C;
    req = 4'b0010;
    @(negedge clk);
    check("mid_grant_owner", 32'(grant), 32'(4'b0010));
    rst = 1'b1;
    #1;
    check("mid_rst_q", 32'(q), 32'(0));
    check("mid_rst_qbar", 32'(qbar), 32'(8'hFF));
    check("mid_rst_grant", 32'(grant), 32'(0));
    check("mid_rst_ack", 32'(ack), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ptr = 0;
    @(negedge clk);

    do_abort(3);                    // must leave the pointer at 0
    run_batch(4'b1111, 1'b0, '0);

    for (int b = 0; b < 40; b++) begin
      if ($urandom_range(0, 4) == 0) do_abort(int'($urandom_range(0, N - 1)));
      run_batch(N'($urandom_range(1, (1 << N) - 1)), 1'b0, '0);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
